// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: PC generator plus a DEPTH-entry prefetch FIFO
// feeding decode through a valid/ready handshake. A taken branch or jump from
// EX flushes the queue and restarts fetch at the target PC.
module fetch_prefetch_queue #(
  parameter int PC_W     = 9,
  parameter int INS_W    = 32,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           redirect,
  input  logic [PC_W-1:0]                redirect_pc,
  output logic                           imem_req,
  output logic [PC_W-1:0]                imem_addr,
  input  logic [INS_W-1:0]               imem_rdata,
  output logic                           id_valid,
  input  logic                           id_ready,
  output logic [PC_W-1:0]                id_pc,
  output logic [INS_W-1:0]               id_instr,
  output logic [$clog2(DEPTH+1)-1:0]     q_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  req_pc;
  logic             inflight;
  logic [PC_W-1:0]  q_pc   [DEPTH];
  logic [INS_W-1:0] q_ins  [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_used;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The in-flight response already owns a slot, so it counts against the credit.
  assign credit_used = {1'b0, count} + (CNT_W + 1)'(inflight);
  assign imem_req    = !reset && !redirect && (credit_used < (CNT_W + 1)'(DEPTH));
  assign imem_addr   = fetch_pc;

  // A redirect discards the response in flight and ignores decode's pop.
  assign push = inflight && !redirect && !reset;
  assign pop  = id_valid && id_ready && !redirect && !reset;

  assign id_valid = !reset && (count != '0);
  assign id_pc    = id_valid ? q_pc[rd_ptr]  : '0;
  assign id_instr = id_valid ? q_ins[rd_ptr] : '0;
  assign q_count  = count;

  // PC generator and outstanding-request tracking; reset beats redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= PC_W'(RESET_PC);
      inflight <= 1'b0;
      req_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + PC_W'(PC_STEP);
        req_pc   <= fetch_pc;
      end
    end
  end

  // Queue pointers and occupancy; a flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]  <= req_pc;
      q_ins[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: an address-tagged instruction
// memory answers one cycle after each request; expected PCs are hand-derived.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [8:0]  id_pc;
  logic [31:0] id_instr;
  logic [2:0]  q_count;

  int n_chk = 0;
  int n_bad = 0;

  fetch_prefetch_queue dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_instr(id_instr), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word tagged with its own address, one cycle latency.
  always @(posedge clk)
    if (imem_req) imem_rdata <= 32'hC0DE_0000 | {23'b0, imem_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [8:0] pc);
    chk({tag, "_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_pc"},    32'(id_pc), 32'(pc));
    chk({tag, "_instr"}, id_instr, 32'hC0DE_0000 | {23'b0, pc});
  endtask

  // Hold reset two cycles, then release; returns in cycle t0 settled.
  task automatic restart(input logic ready);
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = ready;
    tick(); tick();
    reset = 1'b0;
    settle();
  endtask

  initial begin
    imem_rdata = '0;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;

    // Reset state and first-fetch latency, streaming one per cycle.
    tick(); tick(); settle();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_cnt",   32'(q_count), 32'd0);
    chk("rst_pc0",   32'(id_pc), 32'd0);
    tick(); reset = 1'b0; settle();
    chk("t0_req",  32'(imem_req), 32'd1);
    chk("t0_addr", 32'(imem_addr), 32'd0);
    tick(); settle();
    chk("t1_valid", 32'(id_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(); settle();
      chk_head("stream", 9'(i * 4));
      chk("stream_cnt", 32'(q_count <= 3'd1), 32'd1);
    end

    // Stall until the queue is full, then drain with no gap.
    restart(1'b0);
    for (int i = 0; i < 9; i++) tick();
    settle();
    chk("full_cnt",  32'(q_count), 32'd4);
    chk("full_req",  32'(imem_req), 32'd0);
    chk("full_addr", 32'(imem_addr), 32'd16);
    id_ready = 1'b1; settle();
    chk_head("drain", 9'd0);
    for (int i = 1; i < 5; i++) begin
      tick(); settle();
      chk_head("drain", 9'(i * 4));
    end

    // Redirect with three queued and one in flight (t4 under stall).
    restart(1'b0);
    for (int i = 0; i < 4; i++) tick();
    settle();
    chk("pre_redir_cnt", 32'(q_count), 32'd3);
    redirect = 1'b1; redirect_pc = 9'h040; settle();
    chk("redir_req", 32'(imem_req), 32'd0);
    tick(); redirect = 1'b0; id_ready = 1'b1; settle();
    chk("redir_cnt",   32'(q_count), 32'd0);
    chk("redir_valid", 32'(id_valid), 32'd0);
    chk("redir_req1",  32'(imem_req), 32'd1);
    chk("redir_addr",  32'(imem_addr), 32'h040);
    tick(); settle();
    chk("redir_gap", 32'(id_valid), 32'd0);
    tick(); settle();
    chk_head("redir", 9'h040);
    tick(); settle();
    chk_head("redir", 9'h044);

    // Back-to-back redirects: the second target wins.
    restart(1'b1);
    for (int i = 0; i < 3; i++) tick();
    redirect = 1'b1; redirect_pc = 9'h040; settle();
    tick(); redirect_pc = 9'h080; settle();
    chk("b2b_req", 32'(imem_req), 32'd0);
    tick(); redirect = 1'b0; settle();
    chk("b2b_addr",  32'(imem_addr), 32'h080);
    chk("b2b_valid", 32'(id_valid), 32'd0);
    tick(); settle();
    chk("b2b_gap", 32'(id_valid), 32'd0);
    tick(); settle();
    chk_head("b2b", 9'h080);
    tick(); settle();
    chk_head("b2b", 9'h084);

    // PC wrap at the top of the 9-bit address space.
    redirect = 1'b1; redirect_pc = 9'h1FC; settle();
    tick(); redirect = 1'b0; settle();
    chk("wrap_addr0", 32'(imem_addr), 32'h1FC);
    tick(); settle();
    chk("wrap_addr1", 32'(imem_addr), 32'h000);
    tick(); settle();
    chk_head("wrap", 9'h1FC);
    tick(); settle();
    chk_head("wrap", 9'h000);

    // Reset (together with a redirect) while full and stalled.
    restart(1'b0);
    for (int i = 0; i < 9; i++) tick();
    settle();
    chk("rfull_cnt", 32'(q_count), 32'd4);
    reset = 1'b1; redirect = 1'b1; redirect_pc = 9'h080; settle();
    chk("rfull_req",   32'(imem_req), 32'd0);
    chk("rfull_valid", 32'(id_valid), 32'd0);
    tick(); reset = 1'b0; redirect = 1'b0; id_ready = 1'b1; settle();
    chk("rfull_cnt0",  32'(q_count), 32'd0);
    chk("rfull_v0",    32'(id_valid), 32'd0);
    chk("rfull_addr",  32'(imem_addr), 32'd0);
    chk("rfull_req1",  32'(imem_req), 32'd1);
    tick(); tick(); settle();
    chk_head("rfull", 9'd0);
    tick(); settle();
    chk_head("rfull", 9'd4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
